// File: rtl/rw_control_sync.sv
// Bus read/write controller: synchronises the asynchronous CS_n/RD_n/WR_n controls
// and turns bus cycles into one-cycle port strobes, control writes and a sticky error flag.
module rw_control_sync #(
  parameter int  DATA_W      = 8,
  parameter int  NUM_PORTS   = 3,
  parameter int  SYNC_STAGES = 2,
  localparam int ADDR_W      = $clog2(NUM_PORTS + 1)
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 CS_n,
  input  logic                 RD_n,
  input  logic                 WR_n,
  input  logic [ADDR_W-1:0]    A,
  input  logic [DATA_W-1:0]    D_in,
  input  logic [NUM_PORTS-1:0] port_dir,
  output logic                 data_bus_oe,
  output logic [NUM_PORTS-1:0] rd_strobe,
  output logic [NUM_PORTS-1:0] wr_strobe,
  output logic                 ctrl_wr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 access_err
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_PORTS);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACTIVE,
    WR_ACTIVE,
    WR_COMMIT,
    HOLD
  } state_t;

  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  // Registered decode of the synchronised {cs_n, rd_n, wr_n}; sets the SYNC_STAGES+1 latency.
  logic [2:0]                  bus_q, bus_d;
  state_t                      state_q, state_d;
  logic                        oe_q, oe_d;
  logic [NUM_PORTS-1:0]        rd_strobe_q, rd_strobe_d;
  logic [NUM_PORTS-1:0]        wr_strobe_q, wr_strobe_d;
  logic                        ctrl_wr_q, ctrl_wr_d;
  logic [DATA_W-1:0]           wr_data_q, wr_data_d;
  logic                        err_q, err_d;
  logic [ADDR_W-1:0]           addr_cap_q, addr_cap_d;
  logic [DATA_W-1:0]           data_cap_q, data_cap_d;

  logic                        cs_n_s, rd_n_s, wr_n_s;
  logic                        rd, wr, clash;
  logic                        err_set, err_clr;
  logic [NUM_PORTS-1:0]        a_hit, cap_hit;
  logic                        a_ctrl, cap_ctrl;

  assign {cs_n_s, rd_n_s, wr_n_s} = bus_q;
  assign rd    = !cs_n_s && !rd_n_s &&  wr_n_s;
  assign wr    = !cs_n_s && !wr_n_s &&  rd_n_s;
  assign clash = !cs_n_s && !rd_n_s && !wr_n_s;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_addr_dec
      assign a_hit[gi]   = (A == ADDR_W'(gi));
      assign cap_hit[gi] = (addr_cap_q == ADDR_W'(gi));
    end
  endgenerate

  assign a_ctrl   = (A == CTRL_ADDR);
  assign cap_ctrl = (addr_cap_q == CTRL_ADDR);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {CS_n, RD_n, WR_n}};
    bus_d  = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d     = state_q;
    oe_d        = oe_q;
    rd_strobe_d = '0;
    wr_strobe_d = '0;
    ctrl_wr_d   = 1'b0;
    wr_data_d   = wr_data_q;
    addr_cap_d  = addr_cap_q;
    data_cap_d  = data_cap_q;
    err_set     = 1'b0;
    err_clr     = 1'b0;

    if (clash) begin
      state_d = HOLD;
      oe_d    = 1'b0;
      err_set = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          oe_d = 1'b0;
          if (rd) begin
            if ((|a_hit) || a_ctrl) begin
              state_d     = RD_ACTIVE;
              oe_d        = 1'b1;
              rd_strobe_d = a_hit;
            end else begin
              state_d = HOLD;
              err_set = 1'b1;
            end
          end else if (wr) begin
            state_d    = WR_ACTIVE;
            addr_cap_d = A;
            data_cap_d = D_in;
          end
        end
        RD_ACTIVE: begin
          if (!rd) begin
            state_d = IDLE;
            oe_d    = 1'b0;
          end
        end
        WR_ACTIVE: begin
          addr_cap_d = A;
          data_cap_d = D_in;
          if (cs_n_s) begin
            state_d = IDLE;
          end else if (wr_n_s) begin
            // Commit decision uses the address held through the last write cycle.
            state_d   = WR_COMMIT;
            wr_data_d = data_cap_q;
            if (|cap_hit) begin
              if (|(cap_hit & port_dir)) err_set = 1'b1;
              else                       wr_strobe_d = cap_hit;
            end else if (cap_ctrl) begin
              ctrl_wr_d = 1'b1;
              err_clr   = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        WR_COMMIT: state_d = IDLE;
        HOLD: begin
          oe_d = 1'b0;
          if (rd_n_s && wr_n_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync_q      <= '1;
      bus_q       <= '1;
      state_q     <= IDLE;
      oe_q        <= 1'b0;
      rd_strobe_q <= '0;
      wr_strobe_q <= '0;
      ctrl_wr_q   <= 1'b0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      addr_cap_q  <= '0;
      data_cap_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      bus_q       <= bus_d;
      state_q     <= state_d;
      oe_q        <= oe_d;
      rd_strobe_q <= rd_strobe_d;
      wr_strobe_q <= wr_strobe_d;
      ctrl_wr_q   <= ctrl_wr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      addr_cap_q  <= addr_cap_d;
      data_cap_q  <= data_cap_d;
    end
  end

  assign data_bus_oe = oe_q;
  assign rd_strobe   = rd_strobe_q;
  assign wr_strobe   = wr_strobe_q;
  assign ctrl_wr     = ctrl_wr_q;
  assign wr_data     = wr_data_q;
  assign access_err  = err_q;

endmodule

// File: tb/tb_rw_control_sync.sv
// Bench for rw_control_sync: directed bus transactions, a cycle-indexed expectation model
// filled from transaction timing rules, and a per-cycle compare process.
module tb_rw_control_sync;
  localparam int NP   = 3;
  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int MAXC = 512;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          CS_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1;
  logic [AW-1:0] A = '0;
  logic [DW-1:0] D_in = '0;
  logic [NP-1:0] port_dir = 3'b001;
  logic          data_bus_oe, ctrl_wr, access_err;
  logic [NP-1:0] rd_strobe, wr_strobe;
  logic [DW-1:0] wr_data;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  // Expected outputs just after each rising edge, indexed by edge number.
  bit          exp_oe   [MAXC];
  bit [NP-1:0] exp_rds  [MAXC];
  bit [NP-1:0] exp_wrs  [MAXC];
  bit          exp_ctrl [MAXC];
  bit [DW-1:0] exp_wd   [MAXC];
  bit          exp_err  [MAXC];

  always #5 CLK = ~CLK;

  rw_control_sync #(.DATA_W(DW), .NUM_PORTS(NP), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .Reset(Reset), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .A(A), .D_in(D_in), .port_dir(port_dir),
    .data_bus_oe(data_bus_oe), .rd_strobe(rd_strobe), .wr_strobe(wr_strobe),
    .ctrl_wr(ctrl_wr), .wr_data(wr_data), .access_err(access_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic bit [NP-1:0] onehot(input int a);
    bit [NP-1:0] v;
    v = '0;
    if (a >= 0 && a < NP) v[a] = 1'b1;
    return v;
  endfunction

  // A read whose RD_n is sampled low on edges s..s+len-1 drives the bus on s+3..s+len+2.
  task automatic model_read(input int s, input int len, input int addr);
    for (int k = s + 3; k <= s + len + 2; k++) if (k < MAXC) exp_oe[k] = 1'b1;
    if (s + 3 < MAXC) exp_rds[s+3] = onehot(addr);
  endtask

  task automatic err_from(input int n, input bit v);
    for (int k = n; k < MAXC; k++) exp_err[k] = v;
  endtask

  // A write released (WR_n sampled high) on edge s+len commits on edge s+len+3.
  task automatic model_write(input int s, input int len, input int addr, input bit [DW-1:0] data);
    int c;
    c = s + len + 3;
    if (c >= MAXC) return;
    if (addr < NP) begin
      if (port_dir[addr]) err_from(c, 1'b1);
      else begin
        exp_wrs[c] = onehot(addr);
        exp_wd[c]  = data;
      end
    end else if (addr == NP) begin
      exp_ctrl[c] = 1'b1;
      exp_wd[c]   = data;
      err_from(c, 1'b0);
    end else begin
      err_from(c, 1'b1);
    end
  endtask

  task automatic model_reset(input int n);
    for (int k = n; k < MAXC; k++) begin
      exp_oe[k] = 1'b0; exp_rds[k] = '0; exp_wrs[k] = '0;
      exp_ctrl[k] = 1'b0; exp_wd[k] = '0; exp_err[k] = 1'b0;
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic rd_txn(input int addr, input int len);
    int s;
    @(negedge CLK);
    s = cyc + 1;
    CS_n = 1'b0; A = AW'(addr); RD_n = 1'b0;
    model_read(s, len, addr);
    $display("txn read  addr=%0d len=%0d start_edge=%0d", addr, len, s);
    goto(s + len - 1);
    RD_n = 1'b1; CS_n = 1'b1;
    goto(s + len + 5);
  endtask

  task automatic wr_txn(input int addr, input bit [DW-1:0] data, input int len);
    int s;
    @(negedge CLK);
    s = cyc + 1;
    CS_n = 1'b0; A = AW'(addr); D_in = data; WR_n = 1'b0;
    model_write(s, len, addr, data);
    $display("txn write addr=%0d data=%02h len=%0d start_edge=%0d", addr, data, len, s);
    goto(s + len - 1);
    WR_n = 1'b1;
    goto(s + len + 1);
    CS_n = 1'b1;
    goto(s + len + 6);
  endtask

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    #2;
    if (checking && Reset && cyc < MAXC) begin
      chk("data_bus_oe", 32'(data_bus_oe), 32'(exp_oe[cyc]));
      chk("rd_strobe",   32'(rd_strobe),   32'(exp_rds[cyc]));
      chk("wr_strobe",   32'(wr_strobe),   32'(exp_wrs[cyc]));
      chk("ctrl_wr",     32'(ctrl_wr),     32'(exp_ctrl[cyc]));
      chk("access_err",  32'(access_err),  32'(exp_err[cyc]));
      if (exp_wrs[cyc] != '0 || exp_ctrl[cyc])
        chk("wr_data", 32'(wr_data), 32'(exp_wd[cyc]));
      chk("strobe_onehot", 32'($countones({rd_strobe, wr_strobe, ctrl_wr}) <= 1), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, edge %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    #3 Reset = 1'b0;
    #1;
    chk("reset_oe",      32'(data_bus_oe), 32'd0);
    chk("reset_rd_stb",  32'(rd_strobe),   32'd0);
    chk("reset_wr_stb",  32'(wr_strobe),   32'd0);
    chk("reset_ctrl_wr", 32'(ctrl_wr),     32'd0);
    chk("reset_wr_data", 32'(wr_data),     32'd0);
    chk("reset_err",     32'(access_err),  32'd0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    checking = 1'b1;
    goto(cyc + 2);

    // Read port 1, RD_n low for 6 sampled cycles.
    @(negedge CLK);
    s = cyc + 1;
    CS_n = 1'b0; A = 2'd1; RD_n = 1'b0;
    model_read(s, 6, 1);
    $display("txn read  addr=1 len=6 start_edge=%0d", s);
    goto(s + 2); chk("t1_oe_early", 32'(data_bus_oe), 32'd0);
    goto(s + 3); chk("t1_oe_rise", 32'(data_bus_oe), 32'd1);
                 chk("t1_rd_strobe", 32'(rd_strobe), 32'h2);
    goto(s + 4); chk("t1_strobe_single", 32'(rd_strobe), 32'd0);
    goto(s + 5); RD_n = 1'b1; CS_n = 1'b1;
    goto(s + 8); chk("t1_oe_held", 32'(data_bus_oe), 32'd1);
    goto(s + 9); chk("t1_oe_fall", 32'(data_bus_oe), 32'd0);
    goto(s + 11);

    rd_txn(2, 2);
    rd_txn(3, 3);
    wr_txn(1, 8'hA5, 4);
    wr_txn(0, 8'h55, 3);
    rd_txn(0, 3);

    // Control register write clears the sticky error.
    @(negedge CLK);
    s = cyc + 1;
    CS_n = 1'b0; A = 2'd3; D_in = 8'h9B; WR_n = 1'b0;
    model_write(s, 4, 3, 8'h9B);
    $display("txn write addr=3 data=9b len=4 start_edge=%0d", s);
    goto(s + 3); WR_n = 1'b1;
    goto(s + 5); CS_n = 1'b1;
    goto(s + 6); chk("t7_err_before", 32'(access_err), 32'd1);
    goto(s + 7); chk("t7_ctrl_wr", 32'(ctrl_wr), 32'd1);
                 chk("t7_wr_data", 32'(wr_data), 32'h9B);
                 chk("t7_err_clear", 32'(access_err), 32'd0);
    goto(s + 8); chk("t7_ctrl_once", 32'(ctrl_wr), 32'd0);
    goto(s + 10);

    // Abort: CS_n rises while WR_n is still low.
    @(negedge CLK);
    s = cyc + 1;
    CS_n = 1'b0; A = 2'd1; D_in = 8'hEE; WR_n = 1'b0;
    $display("txn abort addr=1 start_edge=%0d", s);
    goto(s + 3); CS_n = 1'b1;
    goto(s + 5); WR_n = 1'b1;
    goto(s + 12);

    // Clash during a read of port 2.
    @(negedge CLK);
    s = cyc + 1;
    CS_n = 1'b0; A = 2'd2; RD_n = 1'b0;
    model_read(s, 4, 2);
    err_from(s + 7, 1'b1);
    $display("txn clash addr=2 start_edge=%0d", s);
    goto(s + 3); WR_n = 1'b0;
    goto(s + 6); WR_n = 1'b1;
    goto(s + 7); chk("t9_oe_drop", 32'(data_bus_oe), 32'd0);
                 chk("t9_err_set", 32'(access_err), 32'd1);
    RD_n = 1'b1; CS_n = 1'b1;
    goto(s + 14);
    rd_txn(2, 3);

    // Reset asserted while in WR_ACTIVE.
    @(negedge CLK);
    s = cyc + 1;
    CS_n = 1'b0; A = 2'd1; D_in = 8'h3C; WR_n = 1'b0;
    $display("txn reset-during-write addr=1 start_edge=%0d", s);
    goto(s + 4);
    #2;
    Reset = 1'b0; WR_n = 1'b1;
    model_reset(s + 5);
    #1;
    chk("t10_err_async", 32'(access_err), 32'd0);
    chk("t10_wr_data_async", 32'(wr_data), 32'd0);
    chk("t10_oe_async", 32'(data_bus_oe), 32'd0);
    goto(s + 6); Reset = 1'b1;
    goto(s + 14); CS_n = 1'b1;
    goto(s + 16);

    // Reset during a read; RD_n still low after release starts a fresh read.
    @(negedge CLK);
    s = cyc + 1;
    CS_n = 1'b0; A = 2'd0; RD_n = 1'b0;
    model_read(s, 4, 0);
    $display("txn reset-during-read addr=0 start_edge=%0d", s);
    goto(s + 3); chk("t11_oe_before", 32'(data_bus_oe), 32'd1);
    #2;
    Reset = 1'b0;
    model_reset(s + 4);
    #1;
    chk("t11_oe_async", 32'(data_bus_oe), 32'd0);
    chk("t11_rd_strobe_async", 32'(rd_strobe), 32'd0);
    goto(s + 5); Reset = 1'b1;
    model_read(s + 6, 3, 0);
    goto(s + 8); RD_n = 1'b1; CS_n = 1'b1;
    goto(s + 9); chk("t11_new_read_strobe", 32'(rd_strobe), 32'h1);
    goto(s + 16);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
